apb_requester: RTL and testbench



---
 rtl/apb_requester.sv | 113 +++++++++++
 tb/tb_apb_requester.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: converts a valid/ready command into one
// APB SETUP/ACCESS transfer and reports read data / error, with a wait-state timeout.
module apb_requester #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_inc;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; rsp_valid is a single-cycle pulse with no backpressure.
    assign cmd_ready = (state == IDLE);
    assign fsm_state = state;

    always_comb begin
        wait_inc = wait_cnt;
        if (wait_cnt != TO_VAL) begin
            wait_inc = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite   <= cmd_write;
                        paddr    <= cmd_addr;
                        pwdata   <= cmd_wdata;
                        psel     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready takes priority over a timeout expiring in the same cycle
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == TO_VAL) begin
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: table of single transfers with a bench-side
// APB completer, plus back-to-back and mid-transfer reset sequences.
module tb_apb_requester;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [1:0]    fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;   // pready-low ACCESS cycles before pready=1
        logic [DW-1:0] prd;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat; // cycles from accept edge to rsp_valid cycle
    } vec_t;

    vec_t vecs[8];

    task automatic run_xfer(input vec_t v);
        int  lat;
        int  acc;
        bit  done;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_write = ~v.wr;
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_cmd_ready", cmd_ready, 0);
        check("setup_paddr", paddr, v.addr);
        check("setup_pwrite", pwrite, v.wr);
        check("setup_pwdata", pwdata, v.wdata);
        acc  = 0;
        done = 0;
        lat  = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                done = 1;
            end else begin
                check("access_psel_en", {psel, penable, cmd_ready}, 3'b110);
                check("access_paddr", paddr, v.addr);
                check("access_pwrite", pwrite, v.wr);
                check("access_pwdata", pwdata, v.wdata);
                if (acc == v.waits) begin
                    pready  = 1'b1;
                    prdata  = v.prd;
                    pslverr = v.slverr;
                end else begin
                    pready  = 1'b0;
                    prdata  = 8'hEE;
                    pslverr = 1'b1;
                end
                acc++;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 8'hD1;
        check("rsp_seen", done, 1);
        check("rsp_latency", lat, v.exp_lat);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_err", rsp_err, v.exp_err);
        check("done_psel_en_rdy", {psel, penable, cmd_ready}, 3'b001);
        @(negedge clk);
        check("rsp_pulse_len", rsp_valid, 0);
        check("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
        check("rsp_err_hold", rsp_err, v.exp_err);
        check("idle_paddr_hold", paddr, v.addr);
    endtask

    initial begin
        logic [AW-1:0] b_addr[4];
        logic [DW-1:0] b_data[4];
        int            pulses;

        vecs[0] = '{1'b1, 8'h01, 8'h5A, 0,   8'h00, 1'b0, 8'h00, 1'b0, 3};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 3,   8'hAF, 1'b0, 8'hAF, 1'b0, 6};
        vecs[2] = '{1'b0, 8'h22, 8'h00, 1,   8'h3C, 1'b1, 8'h3C, 1'b1, 4};
        vecs[3] = '{1'b1, 8'h33, 8'hA5, 2,   8'h99, 1'b0, 8'h00, 1'b0, 5};
        vecs[4] = '{1'b0, 8'h44, 8'h00, 15,  8'h77, 1'b0, 8'h77, 1'b0, 18};
        vecs[5] = '{1'b0, 8'h55, 8'h00, 99,  8'h11, 1'b0, 8'h00, 1'b1, 18};
        vecs[6] = '{1'b1, 8'h7F, 8'hC3, 0,   8'h42, 1'b1, 8'h00, 1'b1, 3};
        vecs[7] = '{1'b1, 8'h66, 8'h18, 16,  8'h00, 1'b0, 8'h00, 1'b1, 18};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata},
              {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
        check("rst_state", fsm_state, 2'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_xfer(vecs[i]);

        // Back-to-back: cmd_valid held, zero wait states, alternating write/read
        b_addr = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        b_data = '{8'h0F, 8'hF1, 8'h2E, 8'hD3};
        pulses = 0;
        pready = 1'b1;
        @(negedge clk);
        check("b2b_start_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1; cmd_addr = b_addr[0]; cmd_wdata = b_data[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_setup", {psel, penable, cmd_ready}, 3'b100);
            check("b2b_paddr", paddr, b_addr[i]);
            check("b2b_pwrite", pwrite, (i % 2 == 0));
            prdata = b_data[i] ^ 8'h81;
            @(negedge clk);
            check("b2b_access", {psel, penable, cmd_ready}, 3'b110);
            @(negedge clk);
            check("b2b_rsp_valid", rsp_valid, 1);
            check("b2b_cmd_ready", cmd_ready, 1);
            check("b2b_rdata", rsp_rdata, (i % 2 == 0) ? 8'h00 : (b_data[i] ^ 8'h81));
            check("b2b_err", rsp_err, 0);
            if (rsp_valid) pulses++;
            if (i < 3) begin
                cmd_write = (i % 2 == 1);
                cmd_addr  = b_addr[i+1];
                cmd_wdata = b_data[i+1];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        pready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("b2b_pulse_count", pulses, 4);

        // Reset asserted in the middle of ACCESS
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h99; cmd_wdata = 8'hAA;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_access", {psel, penable}, 2'b11);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata},
              {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst_no_rsp", pulses, 0);
        check("rst_idle_after", {cmd_ready, psel, penable}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
